// File: rtl/output_collector_pkg.sv
// Shared sizing, types and helpers for the systolic-array output collector.
// The optional OUT_RELU_EN macro (see output_collector.sv) uses relu() from here.
package output_collector_pkg;

  localparam int N     = 4;
  localparam int LOG_N = 2;
  localparam int ACC_W = 16;

  // Column write pointer counts 0..N, so it carries one extra bit
  localparam logic [LOG_N:0]   WPTR_FULL = (LOG_N+1)'(N);
  localparam logic [LOG_N:0]   WPTR_LAST = (LOG_N+1)'(N - 1);
  localparam logic [LOG_N-1:0] RPTR_LAST = LOG_N'(N - 1);

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_t_oc;

  // Clamp negative partial sums to zero
  function automatic acc_t relu(input acc_t x);
    return (x < 0) ? '0 : x;
  endfunction

endpackage

// File: rtl/output_collector.sv
// Output collector: gathers one N x N result matrix from the bottom PE row,
// absorbing per-column skew, then drains it row by row with a valid/ready
// handshake. Late or surplus strobes are dropped and latch a sticky overflow.
// Optional build macro: OUT_RELU_EN clamps negative output elements to zero
// on the way out (buffer contents keep the raw values).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_COLLECT | capturing per-column strobes into the buffer, ready_o high
// S_DRAIN   | presenting buf[rptr] on out_row_o until row N-1 is accepted
module output_collector
  import output_collector_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  acc_t [N-1:0]     psum_i,
  input  logic [N-1:0]     acc_valid_i,
  output logic             ready_o,
  output acc_t [N-1:0]     out_row_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             overflow_o
);

  state_t_oc        state;
  logic [LOG_N-1:0] rptr;
  logic             overflow_q;

  acc_t [N-1:0]     rd_row;
  logic [N-1:0]     col_done_nxt;
  logic [N-1:0]     col_ovf;
  logic             drain_done;

  // Last row accepted: every column pointer rewinds on this edge
  assign drain_done = (state == S_DRAIN) && out_ready_i && (rptr == RPTR_LAST);

  for (genvar j = 0; j < N; j++) begin : g_col
    logic [LOG_N:0] wptr;
    acc_t           col_mem [N];
    logic           full;
    logic           wr_en;

    assign full  = (wptr == WPTR_FULL);
    assign wr_en = (state == S_COLLECT) && acc_valid_i[j] && !full;

    // Column is complete after this edge if already full or this write fills it
    assign col_done_nxt[j] = full || (wr_en && (wptr == WPTR_LAST));

    // Any strobe during drain, or onto a full column, is an overflow
    assign col_ovf[j] = acc_valid_i[j] && ((state == S_DRAIN) || full);

    assign rd_row[j] = col_mem[rptr];

    // Per-column capture: independent pointers absorb the wavefront skew
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        wptr <= '0;
      end else if (drain_done) begin
        wptr <= '0;
      end else if (wr_en) begin
        col_mem[wptr[LOG_N-1:0]] <= psum_i[j];
        wptr                     <= wptr + 1'b1;
      end
    end
  end

  // Collect/drain sequencing, row pointer and sticky overflow
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= S_COLLECT;
      rptr       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (|col_ovf) overflow_q <= 1'b1;
      case (state)
        S_COLLECT: begin
          if (&col_done_nxt) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready_i) begin
            if (rptr == RPTR_LAST) begin
              rptr  <= '0;
              state <= S_COLLECT;
            end else begin
              rptr <= rptr + 1'b1;
            end
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

  assign ready_o     = (state == S_COLLECT);
  assign out_valid_o = (state == S_DRAIN);
  assign out_last_o  = (state == S_DRAIN) && (rptr == RPTR_LAST);
  assign overflow_o  = overflow_q;

  // Output row mux: zero outside drain, optional clamp of negative elements
  always_comb begin
    out_row_o = '0;
    if (state == S_DRAIN) begin
      for (int j = 0; j < N; j++) begin
`ifdef OUT_RELU_EN
        out_row_o[j] = relu(rd_row[j]);
`else
        out_row_o[j] = rd_row[j];
`endif
      end
    end
  end

endmodule

// File: tb/tb_output_collector.sv
// Directed self-checking bench for output_collector (N=4, ACC_W=16).
module tb_output_collector;
  import output_collector_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  acc_t [N-1:0]     psum_i;
  logic [N-1:0]     acc_valid_i;
  logic             ready_o;
  acc_t [N-1:0]     out_row_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             out_last_o;
  logic             overflow_o;

  int checks   = 0;
  int failures = 0;

  output_collector dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .psum_i      (psum_i),
    .acc_valid_i (acc_valid_i),
    .ready_o     (ready_o),
    .out_row_o   (out_row_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_last_o  (out_last_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_row(input int base, input int r);
    logic [63:0] e;
    e = '0;
    for (int j = 0; j < N; j++) e[j*ACC_W +: ACC_W] = ACC_W'(base + 10*r + j);
    return e;
  endfunction

  // All columns strobe together for four cycles: value base+10*row+col
  task automatic fill_all(input int base);
    for (int r = 0; r < N; r++) begin
      acc_valid_i = '1;
      for (int j = 0; j < N; j++) psum_i[j] = acc_t'(base + 10*r + j);
      if (r == N-1) chk("ready_before_last_fill", 64'(ready_o), 64'd1);
      tick();
    end
    acc_valid_i = '0;
  endtask

  // Drain four rows with out_ready_i held high, checking each row
  task automatic drain_check(input int base, input string tag);
    out_ready_i = 1'b1;
    for (int r = 0; r < N; r++) begin
      chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
      chk({tag, "_row"}, out_row_o, exp_row(base, r));
      chk({tag, "_last"}, 64'(out_last_o), 64'(r == N-1));
      tick();
    end
    chk({tag, "_ready_back"}, 64'(ready_o), 64'd1);
    chk({tag, "_valid_off"}, 64'(out_valid_o), 64'd0);
  endtask

  initial begin
    logic [63:0] relu_exp;

    rst_ni      = 1'b0;
    psum_i      = '0;
    acc_valid_i = '0;
    out_ready_i = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_last", 64'(out_last_o), 64'd0);
    chk("rst_row", out_row_o, 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Skewed fill: column j strobes on cycles j..j+3
    out_ready_i = 1'b1;
    for (int c = 0; c < 2*N-1; c++) begin
      for (int j = 0; j < N; j++) begin
        acc_valid_i[j] = (c >= j) && (c <= j + N - 1);
        psum_i[j]      = acc_t'(10*(c - j) + j);
      end
      tick();
      if (c == 2*N-3) begin
        chk("skew_not_done_ready", 64'(ready_o), 64'd1);
        chk("skew_not_done_valid", 64'(out_valid_o), 64'd0);
      end
    end
    acc_valid_i = '0;
    drain_check(0, "skew");
    chk("skew_no_ovf", 64'(overflow_o), 64'd0);

    // Simultaneous completion, then backpressure on row 1
    out_ready_i = 1'b0;
    fill_all(100);
    chk("simul_valid", 64'(out_valid_o), 64'd1);
    chk("simul_row0", out_row_o, exp_row(100, 0));
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid_held", 64'(out_valid_o), 64'd1);
      chk("bp_row1_held", out_row_o, exp_row(100, 1));
      chk("bp_last_low", 64'(out_last_o), 64'd0);
      tick();
    end
    out_ready_i = 1'b1;
    for (int r = 1; r < N; r++) begin
      chk("bp_row", out_row_o, exp_row(100, r));
      chk("bp_last", 64'(out_last_o), 64'(r == N-1));
      tick();
    end
    chk("bp_ready_back", 64'(ready_o), 64'd1);

    // Overflow: column 2 gets a 5th strobe before the others finish
    out_ready_i = 1'b0;
    for (int r = 0; r < N-1; r++) begin
      acc_valid_i = '1;
      for (int j = 0; j < N; j++) psum_i[j] = acc_t'(200 + 10*r + j);
      tick();
    end
    acc_valid_i = 4'b0100;
    psum_i[2]   = acc_t'(232);
    tick();
    chk("ovf_clear_before_5th", 64'(overflow_o), 64'd0);
    psum_i[2] = acc_t'(7777);
    tick();
    chk("ovf_5th_set", 64'(overflow_o), 64'd1);
    chk("ovf_still_collect", 64'(ready_o), 64'd1);
    acc_valid_i = 4'b1011;
    for (int j = 0; j < N; j++) psum_i[j] = acc_t'(230 + j);
    tick();
    chk("ovf_drain_row0", out_row_o, exp_row(200, 0));
    // Strobe during drain: ignored, output unchanged
    acc_valid_i = '1;
    for (int j = 0; j < N; j++) psum_i[j] = acc_t'(5555);
    tick();
    acc_valid_i = '0;
    chk("ovf_drain_strobe_row", out_row_o, exp_row(200, 0));
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    drain_check(200, "ovf");
    chk("ovf_sticky_after", 64'(overflow_o), 64'd1);

    // Reset mid-drain after row 1 accepted
    out_ready_i = 1'b0;
    fill_all(300);
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("mid_row2_shown", out_row_o, exp_row(300, 2));
    rst_ni = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_ovf", 64'(overflow_o), 64'd0);
    chk("mid_rst_row", out_row_o, 64'd0);
    rst_ni = 1'b1;
    tick();
    chk("mid_idle_valid", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b0;
    fill_all(400);
    drain_check(400, "fresh");

    // Negative and positive elements through the output stage
    out_ready_i = 1'b0;
    for (int r = 0; r < N; r++) begin
      acc_valid_i = '1;
      psum_i[0] = acc_t'(-5);
      psum_i[1] = acc_t'(7);
      psum_i[2] = acc_t'(0);
      psum_i[3] = acc_t'(3);
      tick();
    end
    acc_valid_i = '0;
`ifdef OUT_RELU_EN
    relu_exp = {16'd3, 16'd0, 16'd7, 16'd0};
`else
    relu_exp = {16'd3, 16'd0, 16'd7, 16'hFFFB};
`endif
    out_ready_i = 1'b1;
    for (int r = 0; r < N; r++) begin
      chk("relu_row", out_row_o, relu_exp);
      tick();
    end
    chk("relu_ready_back", 64'(ready_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_collector.md
OUTPUT_COLLECTOR -- requirements
Module: output_collector

Interface
REQ-001 SHALL take parameters from pkg: N (array dimension), LOG_N, ACC_W (signed partial-sum width); no local parameters.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port psum_i  input  [N] x ACC_W signed  south outputs of the bottom PE row, one per column.
REQ-005 SHALL have port acc_valid_i  input  [N] x 1  per-column capture strobe from the array controller.
REQ-006 SHALL have port ready_o  output  1  high in S_COLLECT only; drives the controller's ready input.
REQ-007 SHALL have port out_row_o  output  [N] x ACC_W signed  one result row of C during drain.
REQ-008 SHALL have port out_valid_o  output  1  out_row_o holds a valid row.
REQ-009 SHALL have port out_ready_i  input  1  downstream accepts the row.
REQ-010 SHALL have port out_last_o  output  1  high with out_valid_o on row N-1.
REQ-011 SHALL have port overflow_o  output  1  sticky error flag.

Function
REQ-012 SHALL hold an N x N result buffer, a per-column write pointer wptr[j] (LOG_N+1 bits) and a row read pointer rptr (LOG_N bits).
REQ-013 SHALL use state machine state_t_oc {S_COLLECT, S_DRAIN}.
REQ-014 In S_COLLECT, when acc_valid_i[j]=1 and wptr[j]<N, SHALL write psum_i[j] to buf[wptr[j]][j] and increment wptr[j]; columns are independent, so skewed arrival is absorbed.
REQ-015 In S_COLLECT, when acc_valid_i[j]=1 and wptr[j]==N, SHALL drop the sample and set overflow_o.
REQ-016 SHALL move S_COLLECT -> S_DRAIN on the edge where every wptr[j] reaches N, including when several columns complete on the same edge; the first row is visible the cycle after the final write.
REQ-017 In S_DRAIN, SHALL drive out_valid_o=1 and out_row_o=buf[rptr], and SHALL hold both stable while out_ready_i=0.
REQ-018 On out_valid_o && out_ready_i, SHALL increment rptr; on the handshake of row N-1, SHALL clear rptr and all wptr and return to S_COLLECT on the next cycle.
REQ-019 In S_DRAIN, acc_valid_i=1 on any column SHALL be ignored and SHALL set overflow_o.
REQ-020 Outside S_DRAIN, SHALL drive out_valid_o=0, out_last_o=0 and out_row_o='0.
REQ-021 overflow_o SHALL clear only on reset.

Reset
REQ-022 While rst_ni=0 at posedge, SHALL force state=S_COLLECT, wptr=0, rptr=0 and overflow_o=0; buffer contents are don't-care.
REQ-023 Reset values SHALL be: ready_o=1, out_valid_o=0, out_last_o=0, out_row_o='0, overflow_o=0.
REQ-024 Reset during S_DRAIN SHALL abort the drain; the partial matrix is discarded with no further out_valid_o.

Configuration
REQ-025 Macro OUT_RELU_EN: when defined, SHALL drive each negative out_row_o element as 0 (positive and zero elements pass unchanged); when undefined, SHALL drive raw signed values. Buffer contents are unaffected either way.

Structure
REQ-026 pkg SHALL hold N, LOG_N, ACC_W, the acc_t signed type and the state_t_oc enum.
REQ-027 SHALL instantiate no sub-modules; per-column pointer/write logic SHALL be a generate loop.

Verification (N=4, ACC_W=16)
REQ-028 Skewed fill: column j strobes on cycles j..j+3 with values 10*row+j, out_ready_i=1 -> four rows [0,1,2,3],[10,11,12,13],[20,21,22,23],[30,31,32,33] on consecutive cycles, out_last_o on the 4th, ready_o back high the cycle after.
REQ-029 Backpressure: out_ready_i=0 for 3 cycles on row 1 -> row 1 held stable with out_valid_o=1, no row skipped or duplicated.
REQ-030 Overflow: 5th strobe on column 2 before drain -> overflow_o=1 and sticky, drained data equals first 4 samples; strobe during S_DRAIN -> overflow_o=1, output unchanged.
REQ-031 Reset mid-drain: rst_ni=0 after row 1 accepted -> next cycle out_valid_o=0, ready_o=1, and a fresh fill drains correctly from row 0.
REQ-032 OUT_RELU_EN: psum -5 and 7 -> output 0 and 7 with macro defined, -5 and 7 without.
REQ-033 Simultaneous completion: all columns write their 4th sample on the same edge -> S_DRAIN entered, first row valid the next cycle.
